// File: rtl/dds_freq_meter.sv
// Measures an incoming sampled sinusoid over 2**NP_W rising crossings and
// returns the equivalent DDS tuning word 2**(ROM_AW+NP_W) / sample_count.
module dds_freq_meter #(
  parameter int ROM_AW = 8,
  parameter int ROM_DW = 8,
  parameter int NP_W   = 4,
  parameter int CNT_W  = 16,
  parameter int HYST   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sample_vld,
  input  logic signed [ROM_DW-1:0] sample,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ROM_AW-1:0]        kout
);

  localparam int QW = ROM_AW + NP_W + 1;
  localparam int SW = $clog2(QW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [NP_W-1:0]  PER_MAX = '1;
  localparam logic signed [ROM_DW-1:0] HP = ROM_DW'(HYST);
  localparam logic signed [ROM_DW-1:0] HN = -HP;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_pol;
  logic [CNT_W-1:0]  r_cnt;
  logic [NP_W-1:0]   r_per;
  logic [CNT_W-1:0]  r_rem;
  logic [QW-1:0]     r_q;
  logic [SW-1:0]     r_step;
  logic [ROM_AW-1:0] r_kout;
  logic              r_err;

  logic             w_pos;
  logic             w_neg;
  logic             w_rx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo;
  logic             w_last_per;
  logic [CNT_W:0]   w_trial;
  logic             w_ge;
  logic [QW-1:0]    w_q_nx;
  logic             w_last_step;
  logic             w_ovr;

  assign w_pos       = sample >= HP;
  assign w_neg       = sample <= HN;
  assign w_rx        = sample_vld & ~r_pol & w_pos;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_tmo       = sample_vld & (w_cnt_inc == CNT_MAX);
  assign w_last_per  = r_per == PER_MAX;
  assign w_trial     = {r_rem, r_q[QW-1]};
  assign w_ge        = w_trial >= {1'b0, r_cnt};
  assign w_q_nx      = {r_q[QW-2:0], w_ge};
  assign w_last_step = r_step == SW'(QW - 1);
  assign w_ovr       = |w_q_nx[QW-1:ROM_AW];

  assign kout = r_kout;
  assign err  = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_ARM;
      S_ARM: begin
        busy = 1'b1;
        if (w_rx)       w_next = S_MEAS;
        else if (w_tmo) w_next = S_DONE;
      end
      S_MEAS: begin
        busy = 1'b1;
        if (w_rx && w_last_per) w_next = S_DIV;
        else if (w_tmo)         w_next = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last_step) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Polarity tracker runs in every state so the first crossing after
  // start is a genuine NEG->POS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pol  <= 1'b0;
      r_cnt  <= '0;
      r_per  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_step <= '0;
      r_kout <= '0;
      r_err  <= 1'b0;
    end else begin
      if (sample_vld) begin
        if (w_pos)      r_pol <= 1'b1;
        else if (w_neg) r_pol <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_per <= '0;
          end
        end
        S_ARM: begin
          if (w_rx) begin
            r_cnt <= '0;
            r_per <= '0;
          end else if (sample_vld) begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) begin
              r_kout <= '0;
              r_err  <= 1'b1;
            end
          end
        end
        S_MEAS: begin
          if (sample_vld) r_cnt <= w_cnt_inc;
          if (w_rx) r_per <= r_per + 1'b1;
          if (w_rx && w_last_per) begin
            r_rem  <= '0;
            r_q    <= {1'b1, {(QW-1){1'b0}}};
            r_step <= '0;
          end else if (w_tmo) begin
            r_kout <= '0;
            r_err  <= 1'b1;
          end
        end
        S_DIV: begin
          // r_q shifts numerator bits out the top and quotient bits in.
          r_rem  <= w_ge ? CNT_W'(w_trial - {1'b0, r_cnt})
                         : w_trial[CNT_W-1:0];
          r_q    <= w_q_nx;
          r_step <= r_step + 1'b1;
          if (w_last_step) begin
            r_kout <= w_ovr ? '1 : w_q_nx[ROM_AW-1:0];
            r_err  <= w_ovr;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: DDS-style sine stimulus, reference result
// derived from crossing positions in the valid-sample stream.
module tb_dds_freq_meter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NPW = 4;
  localparam int CW  = 16;
  localparam int HY  = 4;
  localparam int LAT = AW + NPW + 2;
  localparam int NUM = 1 << (AW + NPW);
  localparam int NRX = (1 << NPW) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 sample_vld;
  logic signed [DW-1:0] sample;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [AW-1:0]        kout;

  always #5 clk = ~clk;

  dds_freq_meter #(
    .ROM_AW(AW),
    .ROM_DW(DW),
    .NP_W  (NPW),
    .CNT_W (CW),
    .HYST  (HY)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample_vld(sample_vld),
    .sample    (sample),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .kout      (kout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vcount = 0;
  bit mpol = 1'b0;
  bit meas = 1'b0;
  int rx_idx[$];
  int rx_tick[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive, let the DUT capture, then update the polarity model.
  task automatic tick(input bit r, input bit st, input bit v, input int s);
    rst        = r;
    start      = st;
    sample_vld = v;
    sample     = DW'(s);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mpol = 1'b0;
      meas = 1'b0;
    end else if (v) begin
      vcount++;
      if (s >= HY) begin
        if (!mpol && meas) begin
          rx_idx.push_back(vcount);
          rx_tick.push_back(cyc);
        end
        mpol = 1'b1;
      end else if (s <= -HY) begin
        mpol = 1'b0;
      end
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  function automatic int dds(input int ph, input int amp);
    real x;
    x = amp * $sin(6.283185307179586 * ph / 256.0);
    return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
  endfunction

  task automatic run_meas(input string tag, input int kin, input int amp,
                          input int duty, input bit noisy, input int ph0,
                          output int ek);
    int ph;
    int s;
    bit v;
    bit got;
    int dt;
    int cnt;
    bit ee;
    ph  = (ph0 < 0) ? int'($urandom_range(0, 255)) : ph0;
    got = 1'b0;
    dt  = 0;
    ek  = -1;
    ee  = 1'b0;
    rx_idx.delete();
    rx_tick.delete();
    vcount = 0;
    tick(1'b0, 1'b1, 1'b0, 0);
    meas = 1'b1;
    chk({tag, "_busy"}, busy, 1);
    for (int n = 0; n < 8000 && !got; n++) begin
      v = $urandom_range(0, 99) < duty;
      if (v) begin
        s = dds(ph, amp);
        if (noisy && s > -8 && s < 8) s += int'($urandom_range(0, 6)) - 3;
        ph = (ph + kin) % 256;
      end else begin
        s = int'($urandom_range(0, 255)) - 128;
      end
      tick(1'b0, $urandom_range(0, 63) == 0, v, s);
      if (done) begin
        got = 1'b1;
        dt  = cyc;
      end
    end
    meas = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk({tag, "_rx_enough"}, rx_idx.size() >= NRX, 1);
      if (rx_idx.size() >= NRX) begin
        cnt = rx_idx[NRX-1] - rx_idx[0];
        ek  = NUM / cnt;
        ee  = ek >= (1 << AW);
        if (ee) ek = (1 << AW) - 1;
        // The final sample occupies the cycle before its capturing edge.
        chk({tag, "_latency"}, dt - rx_tick[NRX-1] + 1, LAT);
      end
      chk({tag, "_kout"}, kout, ek);
      chk({tag, "_err"}, err, ee);
      tick(1'b0, 1'b1, 1'b0, 0);
      chk({tag, "_one_pulse"}, done, 0);
      chk({tag, "_start_in_done"}, busy, 0);
      chk({tag, "_kout_held"}, kout, ek);
    end
  endtask

  initial begin
    int k;
    int ph;
    int n_done;
    bit got;
    int tn;
    rst        = 1'b1;
    start      = 1'b0;
    sample_vld = 1'b0;
    sample     = '0;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kout", kout, 0);

    run_meas("k16", 16, 100, 100, 1'b0, 0, k);
    chk("k16_const", kout, 16);
    run_meas("k3", 3, 120, 100, 1'b0, -1, k);
    run_meas("noise", 16, 100, 100, 1'b1, 0, k);
    chk("noise_const", kout, 16);
    run_meas("vld50", 16, 90, 50, 1'b0, 0, k);
    chk("vld50_const", kout, 16);
    for (int i = 0; i < 4; i++)
      run_meas($sformatf("rnd%0d", i), int'($urandom_range(6, 40)),
               int'($urandom_range(20, 120)), int'($urandom_range(60, 100)),
               1'b0, -1, k);

    // Abort mid-measurement with a reset pulse.
    tick(1'b0, 1'b1, 1'b0, 0);
    meas = 1'b1;
    ph   = 0;
    for (int n = 0; n < 100; n++) begin
      tick(1'b0, 1'b0, 1'b1, dds(ph, 100));
      ph = (ph + 16) % 256;
    end
    chk("abort_busy_before", busy, 1);
    tick(1'b1, 1'b0, 1'b0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_kout", kout, 0);
    chk("abort_err", err, 0);
    n_done = 0;
    for (int n = 0; n < 20; n++) begin
      tick(1'b0, 1'b0, 1'b1, 50);
      n_done += int'(done);
    end
    chk("abort_no_done", n_done, 0);
    run_meas("after_abort", 16, 100, 100, 1'b0, 0, k);
    chk("after_abort_const", kout, 16);

    // No crossings at all: saturating counter forces the timeout result.
    vcount = 0;
    got    = 1'b0;
    tn     = 0;
    tick(1'b0, 1'b1, 1'b0, 0);
    for (int n = 0; n < 70000 && !got; n++) begin
      tick(1'b0, 1'b0, 1'b1, 0);
      if (done) begin
        got = 1'b1;
        tn  = vcount;
      end
    end
    chk("tmo_done_seen", got, 1);
    chk("tmo_samples", tn, (1 << CW) - 1);
    chk("tmo_err", err, 1);
    chk("tmo_kout", kout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
